// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the main control decoder: opcodes, control-word bit map and encodings.
// MemByte (bit 13) is only driven when the decoder is built with CTRL_BYTE_MEM_EN.
package cpu_ctrl_pkg;

   typedef logic [13:0] ctrl_word_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_COP0  = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int CB_MEM_BYTE      = 13;
   localparam int CB_ALU_OP        = 12;
   localparam int CB_ALU_SRC_A     = 11;
   localparam int CB_ALU_SRC_B_LSB = 9;
   localparam int CB_REG_DST_LSB   = 7;
   localparam int CB_MEM2REG       = 6;
   localparam int CB_REG_WRITE     = 5;
   localparam int CB_MEM_READ      = 4;
   localparam int CB_MEM_WRITE     = 3;
   localparam int CB_PC_SRC        = 2;
   localparam int CB_PC_WRITE_COND = 1;
   localparam int CB_PC_WRITE      = 0;

   localparam logic [1:0] SRCB_RB     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] RDST_RT  = 2'b00;
   localparam logic [1:0] RDST_RD  = 2'b01;
   localparam logic [1:0] RDST_R31 = 2'b10;

   // Field order matches the bit map from MemByte down to PCWrite; PCSrc is tied to 0.
   function automatic ctrl_word_t cw(input logic mem_byte, input logic alu_op, input logic src_a,
                                     input logic [1:0] src_b, input logic [1:0] reg_dst,
                                     input logic mem2reg, input logic reg_write,
                                     input logic mem_read, input logic mem_write,
                                     input logic pc_write_cond, input logic pc_write);
      return {mem_byte, alu_op, src_a, src_b, reg_dst, mem2reg, reg_write,
              mem_read, mem_write, 1'b0, pc_write_cond, pc_write};
   endfunction

   localparam ctrl_word_t CW_RTYPE = cw(1'b0, 1'b1, 1'b1, SRCB_RB,     RDST_RD,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   localparam ctrl_word_t CW_J     = cw(1'b0, 1'b0, 1'b0, SRCB_RB,     RDST_RT,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   localparam ctrl_word_t CW_JAL   = cw(1'b0, 1'b0, 1'b0, SRCB_RB,     RDST_R31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   localparam ctrl_word_t CW_BRANCH= cw(1'b0, 1'b0, 1'b0, SRCB_IMM_SH, RDST_RT,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   localparam ctrl_word_t CW_ALUI  = cw(1'b0, 1'b0, 1'b1, SRCB_IMM,    RDST_RT,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   localparam ctrl_word_t CW_COP0  = cw(1'b0, 1'b0, 1'b1, SRCB_RB,     RDST_RT,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   localparam ctrl_word_t CW_LW    = cw(1'b0, 1'b0, 1'b1, SRCB_IMM,    RDST_RT,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   localparam ctrl_word_t CW_SW    = cw(1'b0, 1'b0, 1'b1, SRCB_IMM,    RDST_RT,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   localparam ctrl_word_t CW_LBU   = cw(1'b1, 1'b0, 1'b1, SRCB_IMM,    RDST_RT,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   localparam ctrl_word_t CW_SB    = cw(1'b1, 1'b0, 1'b1, SRCB_IMM,    RDST_RT,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode -> 14-bit control word (combinational) plus a sticky registered illegal-opcode flag.
// Byte loads/stores (lbu, sb) decode only when CTRL_BYTE_MEM_EN is defined.
module ctrl_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_en,
   input  logic [5:0]  op,
   output logic [13:0] signal,
   output logic        illegal
);

   ctrl_word_t sig_c;
   logic       legal_c;
   logic       illegal_d;
   logic       illegal_q;

   always_comb begin
      sig_c   = '0;
      legal_c = 1'b1;
      case (op)
         OP_RTYPE:                     sig_c = CW_RTYPE;
         OP_J:                         sig_c = CW_J;
         OP_JAL:                       sig_c = CW_JAL;
         OP_BEQ, OP_BNE:               sig_c = CW_BRANCH;
         OP_ADDI, OP_ADDIU, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI,
         OP_LUI:                       sig_c = CW_ALUI;
         OP_COP0:                      sig_c = CW_COP0;
         OP_LW:                        sig_c = CW_LW;
         OP_SW:                        sig_c = CW_SW;
`ifdef CTRL_BYTE_MEM_EN
         OP_LBU:                       sig_c = CW_LBU;
         OP_SB:                        sig_c = CW_SB;
`endif
         default:                      legal_c = 1'b0;
      endcase
   end

   assign illegal_d = illegal_q | (dec_en & ~legal_c);

   always_ff @(posedge clk) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end

   assign signal  = sig_c;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_decoder.sv
// Directed table-driven bench for ctrl_decoder: full opcode sweep, key vectors, sticky-flag sequences.
module tb_ctrl_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_en;
   logic [5:0]  op;
   logic [13:0] signal;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   ctrl_decoder dut (
      .clk     (clk),
      .rst     (rst),
      .dec_en  (dec_en),
      .op      (op),
      .signal  (signal),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [13:0] sig;
   } vec_t;

   vec_t vecs[14];

   // Hand-written reference table, independent of the package constants.
   function automatic logic [13:0] ref_sig(input logic [5:0] o);
      case (o)
         6'h00: return 14'h18A0;
         6'h02: return 14'h0001;
         6'h03: return 14'h0121;
         6'h04, 6'h05: return 14'h0602;
         6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return 14'h0C20;
         6'h10: return 14'h0820;
         6'h23: return 14'h0C70;
         6'h2B: return 14'h0C08;
`ifdef CTRL_BYTE_MEM_EN
         6'h24: return 14'h2C70;
         6'h28: return 14'h2C08;
`endif
         default: return 14'h0000;
      endcase
   endfunction

   task automatic chk_sig(input string name, input logic [13:0] exp);
      total++;
      if (signal !== exp) begin
         bad++;
         $display("FAIL %s: op=%h signal=%h expected=%h", name, op, signal, exp);
      end
   endtask

   task automatic chk_ill(input string name, input logic exp);
      total++;
      if (illegal !== exp) begin
         bad++;
         $display("FAIL %s: illegal=%b expected=%b", name, illegal, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{6'h23, 14'h0C70};
      vecs[1]  = '{6'h2B, 14'h0C08};
      vecs[2]  = '{6'h03, 14'h0121};
      vecs[3]  = '{6'h04, 14'h0602};
      vecs[4]  = '{6'h05, 14'h0602};
      vecs[5]  = '{6'h10, 14'h0820};
      vecs[6]  = '{6'h0F, 14'h0C20};
      vecs[7]  = '{6'h02, 14'h0001};
      vecs[8]  = '{6'h00, 14'h18A0};
      vecs[9]  = '{6'h3F, 14'h0000};
      vecs[10] = '{6'h0A, 14'h0000};
`ifdef CTRL_BYTE_MEM_EN
      vecs[11] = '{6'h24, 14'h2C70};
      vecs[12] = '{6'h28, 14'h2C08};
`else
      vecs[11] = '{6'h24, 14'h0000};
      vecs[12] = '{6'h28, 14'h0000};
`endif
      vecs[13] = '{6'h08, 14'h0C20};

      // Reset: flag cleared, decode still live while rst is high.
      rst = 1'b1; dec_en = 1'b1; op = 6'h23;
      tick(); tick();
      chk_ill("reset_flag", 1'b0);
      chk_sig("sig_during_reset", 14'h0C70);
      rst = 1'b0; dec_en = 1'b0;

      // Full sweep with dec_en=0: exact decode, flag never moves.
      for (int i = 0; i < 64; i++) begin
         op = 6'(i);
         #1;
         chk_sig("sweep", ref_sig(6'(i)));
         tick();
         chk_ill("sweep_flag", 1'b0);
      end

      // Directed vector table.
      for (int i = 0; i < 14; i++) begin
         op = vecs[i].op;
         #1;
         chk_sig("vec", vecs[i].sig);
      end

      // Legal ops under dec_en=1 leave the flag clear.
      dec_en = 1'b1;
      op = 6'h02; tick(); chk_ill("j_no_flag", 1'b0);
      op = 6'h10; tick(); chk_ill("cop0_no_flag", 1'b0);
      op = 6'h0F; tick(); chk_ill("lui_no_flag", 1'b0);

      // Illegal op sets the flag; it is registered, not combinational.
      op = 6'h3F; #1;
      chk_ill("flag_before_edge", 1'b0);
      tick();
      chk_ill("flag_set", 1'b1);
      op = 6'h00; tick();
      chk_ill("flag_sticky", 1'b1);
      dec_en = 1'b0; op = 6'h23; tick();
      chk_ill("flag_sticky_noen", 1'b1);

      // Reset wins over a simultaneous illegal decode.
      rst = 1'b1; dec_en = 1'b1; op = 6'h3F;
      #1; chk_sig("sig_3f_in_reset", 14'h0000);
      tick();
      chk_ill("reset_wins", 1'b0);
      chk_sig("sig_3f_after_reset", 14'h0000);
      rst = 1'b0;

      // Illegal ops with dec_en=0 are ignored.
      dec_en = 1'b0;
      op = 6'h3F; tick();
      op = 6'h01; tick();
      chk_ill("noen_ignored", 1'b0);

      // Byte memory ops: legal only when the feature is built in.
      dec_en = 1'b1; op = 6'h24; tick();
`ifdef CTRL_BYTE_MEM_EN
      chk_ill("lbu_flag", 1'b0);
`else
      chk_ill("lbu_flag", 1'b1);
`endif
      rst = 1'b1; tick(); rst = 1'b0;
      chk_ill("reset_again", 1'b0);
      op = 6'h28; tick();
`ifdef CTRL_BYTE_MEM_EN
      chk_ill("sb_flag", 1'b0);
`else
      chk_ill("sb_flag", 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
